// File: rtl/svcs_hs_frame_tx.sv
// Multi-channel SVCS handshake transmit framer: round-robin command arbitration,
// four-word header then payload words on one registered valid/ready stream.
module svcs_hs_frame_tx #(
    parameter int  DATA_W       = 32,
    parameter int  N_CH         = 4,
    parameter int  MAX_PAYLOADS = 4096,
    localparam int CNT_W        = $clog2(MAX_PAYLOADS + 1),
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        cmd_valid,
    output logic [N_CH-1:0]        cmd_ready,
    input  logic [N_CH*DATA_W-1:0] cmd_trnx_type,
    input  logic [N_CH*DATA_W-1:0] cmd_trnx_id,
    input  logic [N_CH*DATA_W-1:0] cmd_data_type,
    input  logic [N_CH*CNT_W-1:0]  cmd_n_payloads,
    input  logic [N_CH-1:0]        pl_valid,
    output logic [N_CH-1:0]        pl_ready,
    input  logic [N_CH*DATA_W-1:0] pl_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [CH_W-1:0]        out_ch,
    output logic                   busy,
    output logic                   err_oversize,
    output logic [15:0]            frames_sent
);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_PAYLOADS);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d, grant_q, grant_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0]  n_q, n_d, rem_q, rem_d;
    logic [DATA_W-1:0] id_q, id_d, dtype_q, dtype_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_q, err_d;
    logic [15:0]       frames_q, frames_d;

    logic [DATA_W-1:0] type_a [N_CH];
    logic [DATA_W-1:0] id_a [N_CH];
    logic [DATA_W-1:0] dtype_a [N_CH];
    logic [DATA_W-1:0] pl_a [N_CH];
    logic [CNT_W-1:0]  n_a [N_CH];

    logic              sel_found;
    logic [CH_W-1:0]   sel_ch, cand;
    logic              out_fire, pl_take, pl_fire;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign type_a[g]  = cmd_trnx_type[g*DATA_W +: DATA_W];
        assign id_a[g]    = cmd_trnx_id[g*DATA_W +: DATA_W];
        assign dtype_a[g] = cmd_data_type[g*DATA_W +: DATA_W];
        assign pl_a[g]    = pl_data[g*DATA_W +: DATA_W];
        assign n_a[g]     = cmd_n_payloads[g*CNT_W +: CNT_W];
    end

    // Descending scan so the lowest offset from rr is the last (winning) hit.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = CH_W'((int'(rr_q) + i) % N_CH);
            if (cmd_valid[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_comb begin
        cmd_ready = '0;
        pl_ready  = '0;
        if (!reset && state_q == IDLE && sel_found) begin
            cmd_ready[sel_ch] = 1'b1;
        end
        pl_take = !reset && state_q == PAY && rem_q != '0 && (!out_valid_q || out_ready);
        pl_ready[grant_q] = pl_take;
    end

    assign out_fire = out_valid_q && out_ready;
    assign pl_fire  = pl_take && pl_valid[grant_q];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        hdr_idx_d   = hdr_idx_q;
        n_d         = n_q;
        rem_d       = rem_q;
        id_d        = id_q;
        dtype_d     = dtype_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        frames_d    = frames_q;
        if (out_fire && out_last_q) begin
            frames_d = frames_q + 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    rr_d = CH_W'((int'(sel_ch) + 1) % N_CH);
                    if (n_a[sel_ch] > MAX_N) begin
                        err_d = 1'b1;
                    end else begin
                        grant_d     = sel_ch;
                        id_d        = id_a[sel_ch];
                        dtype_d     = dtype_a[sel_ch];
                        n_d         = n_a[sel_ch];
                        out_valid_d = 1'b1;
                        out_data_d  = type_a[sel_ch];
                        out_last_d  = 1'b0;
                        hdr_idx_d   = 2'd0;
                        state_d     = HDR;
                    end
                end
            end
            HDR: begin
                if (out_fire) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        case (hdr_idx_q)
                            2'd0:    out_data_d = id_q;
                            2'd1:    out_data_d = dtype_q;
                            default: begin
                                // Enter PAY while word 3 is still in the output
                                // register so its drain can admit payload word 0.
                                out_data_d = DATA_W'(n_q);
                                rem_d      = n_q;
                                if (n_q == '0) begin
                                    out_last_d = 1'b1;
                                end else begin
                                    state_d = PAY;
                                end
                            end
                        endcase
                    end
                end
            end
            PAY: begin
                if (pl_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pl_a[grant_q];
                    rem_d       = rem_q - CNT_W'(1);
                    out_last_d  = (rem_q == CNT_W'(1));
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
                if (out_fire && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            hdr_idx_q   <= '0;
            n_q         <= '0;
            rem_q       <= '0;
            id_q        <= '0;
            dtype_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            hdr_idx_q   <= hdr_idx_d;
            n_q         <= n_d;
            rem_q       <= rem_d;
            id_q        <= id_d;
            dtype_q     <= dtype_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_ch       = grant_q;
    assign busy         = (state_q != IDLE);
    assign err_oversize = err_q;
    assign frames_sent  = frames_q;

endmodule

// File: doc/svcs_hs_frame_tx.md
# svcs_hs_frame_tx

Hardware transmit framer for the SVCS client/server handshake protocol. Arbitrates round-robin among `N_CH` channel command ports and serialises each accepted transaction as a four-word header (trnx_type, trnx_id, data_type, n_payloads) followed by `n_payloads` payload words pulled from the granted channel's payload stream. Output is a single valid/ready word stream toward the socket/DPI bridge. This block is the multi-channel, parametrised-width hardware successor of the software send-header-then-payload sequence.

## Interface
- `DATA_W`, 32: word width of header and payload words; must be ≥ 32.
- `N_CH`, 4: number of channel ports; 1..16.
- `MAX_PAYLOADS`, 4096: largest legal n_payloads per transaction.
- `CNT_W`, $clog2(MAX_PAYLOADS+1): width of n_payloads fields (derived, not overridden).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in N_CH: per-channel command valid.
- `cmd_ready` out N_CH: per-channel command accept; at most one bit high.
- `cmd_trnx_type` in N_CH*DATA_W: per-channel transaction type hash.
- `cmd_trnx_id` in N_CH*DATA_W: per-channel transaction id.
- `cmd_data_type` in N_CH*DATA_W: per-channel data type hash.
- `cmd_n_payloads` in N_CH*CNT_W: per-channel payload word count.
- `pl_valid` in N_CH: per-channel payload word valid.
- `pl_ready` out N_CH: per-channel payload word accept.
- `pl_data` in N_CH*DATA_W: per-channel payload word.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accept.
- `out_data` out DATA_W: output word.
- `out_last` out 1: marks final word of a frame.
- `out_ch` out $clog2(N_CH) (min 1): channel of the current frame.
- `busy` out 1: high in HDR or PAY.
- `err_oversize` out 1: sticky; set when a command with n_payloads > MAX_PAYLOADS is accepted.
- `frames_sent` out 16: count of completed frames, wraps at 65535→0.

## Operation
- States: IDLE, HDR, PAY.
- IDLE: round-robin search starting at pointer `rr`; the first channel with `cmd_valid` gets `cmd_ready`=1 combinationally, and its fields are latched, `grant`=ch, `rr`=(ch+1) mod N_CH.
  - Oversize command: consumed, `err_oversize` set, stays IDLE, no frame, `rr` still advances.
  - Otherwise go to HDR, `hdr_idx`=0.
- HDR: emits words 0..3 = trnx_type, trnx_id, data_type, zero-extended n_payloads; `hdr_idx` advances on each output transfer. After word 3 transfers: PAY if n_payloads>0, else IDLE. If n_payloads=0, `out_last`=1 on word 3.
- PAY: `pl_ready[grant]` = output register empty or being drained (`!out_valid || out_ready`); all other `pl_ready` bits are 0.
  - Each accepted payload word loads the output register and decrements the remaining count.
  - `out_last`=1 on the word where remaining reaches 0; after it transfers, go to IDLE.
- `frames_sent` increments on each `out_last` transfer.
- `cmd_ready` is 0 outside IDLE. `pl_ready` is 0 outside PAY.
- Upstream stall (`pl_valid`=0) inserts bubbles (`out_valid`=0). Downstream stall holds `out_data`, `out_last`, `out_valid` stable.

## Timing
- Output is fully registered; a word is transferred when `out_valid && out_ready`.
- Command accepted in cycle t; header word 0 is valid at t+1. At sustained `out_ready`=1, one word per cycle with no bubble between HDR and PAY.
- Next command is accepted in the cycle after the `out_last` transfer, so there is 1 idle cycle between frames.
- Payload word accepted in cycle t appears on `out_data` at t+1.
- Reset (any state, mid-frame included): state=IDLE, `rr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_ch`=0, `busy`=0, `err_oversize`=0, `frames_sent`=0, `cmd_ready`/`pl_ready`=0 during reset. A partial frame is dropped, not completed.
- Simultaneous valid commands: the lowest index at or after `rr` wins.
- N_CH=1: `rr` is always 0.

## Test plan
- Ch0 command (type=0xA, id=1, dtype=0xB, n=3, payload 0x10,0x11,0x12), `out_ready`=1 → words A,1,B,3,10,11,12 on consecutive cycles starting 1 cycle after accept; `out_last` on 0x12; `frames_sent`=1.
- n_payloads=0 on ch2 → exactly 4 header words, `out_last` on word 3, `out_ch`=2, `pl_ready` never high.
- All 4 channels valid continuously, n=1 each → grant order 0,1,2,3,0; each `cmd_ready` pulses once per round.
- `out_ready` toggling 1/0 and `pl_valid` random during an n=8 frame → output data stable while stalled; all 8 payload words are delivered in order with no duplicates or loss.
- Ch1 command with n=MAX_PAYLOADS+1 → `err_oversize`=1 (sticky), no `out_valid`; a following ch2 command frames normally.
- Reset asserted after 2 payload words of an n=5 frame → next cycle `out_valid`=0, `busy`=0, `frames_sent`=0; a new command gets a full frame.
